// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 instruction decode with an optional skid buffer
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit EN_M = 0,
  parameter bit SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            rd_en,
  output logic            rs1_en,
  output logic            rs2_en,
  output logic            illegal
);
  localparam bit RV64 = XLEN == 64;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rd_en;
    logic            rs1_en;
    logic            rs2_en;
    logic            illegal;
  } dec_t;
  dec_t dec, out_q, skid_q;
  logic full, ready_q, acc, ok;
  logic [6:0] op, f7;
  logic [2:0] f3, f;
  logic signed [31:0] imm32;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  always_comb begin
    ok = 1'b1;
    f = 3'd7;
    case (op)
      7'b0110111, 7'b0010111: f = 3'd4;
      7'b1101111: f = 3'd5;
      7'b1100111: begin f = 3'd1; ok = f3 == 3'b000; end
      7'b1100011: begin f = 3'd3; ok = f3[2:1] != 2'b01; end
      7'b0000011: begin f = 3'd1; ok = f3 != 3'b111 && (RV64 || (f3 != 3'b011 && f3 != 3'b110)); end
      7'b0100011: begin f = 3'd2; ok = !f3[2] && (RV64 || f3 != 3'b011); end
      7'b0010011, 7'b0001111: f = 3'd1;
      7'b1110011: begin f = 3'd1; ok = f3 != 3'b100; end
      7'b0011011: begin f = 3'd1; ok = RV64; end
      7'b0110011, 7'b0111011: begin
        f = 3'd0;
        ok = (!op[3] || RV64) && (f7 == 7'b0000000 || f7 == 7'b0100000 || (EN_M && f7 == 7'b0000001));
      end
      default: ok = 1'b0;
    endcase
    if (!ok) f = 3'd7;
    imm32 = f == 3'd1 ? {{20{in_instr[31]}}, in_instr[31:20]} :
            f == 3'd2 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
            f == 3'd3 ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
            f == 3'd4 ? {in_instr[31:12], 12'b0} :
            f == 3'd5 ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
            32'sd0;
    dec.pc = in_pc;
    dec.instr = in_instr;
    dec.imm = XLEN'(imm32);
    dec.fmt = f;
    dec.illegal = !ok;
    dec.rs1_en = f <= 3'd3;
    dec.rs2_en = f == 3'd0 || f == 3'd2 || f == 3'd3;
    dec.rd_en = (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) && in_instr[11:7] != 5'd0 && op != 7'b0001111;
  end
  assign acc = in_valid && in_ready;
  // without the skid entry, ready must look through to out_ready
  assign in_ready = SKID ? ready_q : rst_n && (!out_valid || out_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      skid_q <= '0;
      out_valid <= 1'b0;
      full <= 1'b0;
      ready_q <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      full <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (full) begin
        if (out_ready) begin
          out_q <= skid_q;
          full <= 1'b0;
        end
      end else if (acc) begin
        if (!out_valid || out_ready) begin
          out_q <= dec;
          out_valid <= 1'b1;
        end else begin
          skid_q <= dec;
          full <= 1'b1;
        end
      end else if (out_ready) out_valid <= 1'b0;
      ready_q <= !(full ? !out_ready : acc && out_valid && !out_ready);
    end
  end
  assign out_pc = out_q.pc;
  assign opcode = out_q.instr[6:0];
  assign rd = out_q.instr[11:7];
  assign rs1 = out_q.instr[19:15];
  assign rs2 = out_q.instr[24:20];
  assign funct3 = out_q.instr[14:12];
  assign funct7 = out_q.instr[31:25];
  assign imm = out_q.imm;
  assign fmt = out_q.fmt;
  assign rd_en = out_q.rd_en;
  assign rs1_en = out_q.rs1_en;
  assign rs2_en = out_q.rs2_en;
  assign illegal = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a spec-level model
module tb_decode_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic [63:0] in_pc = 0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;

  logic in_ready_a, out_valid_a, rd_en_a, rs1_en_a, rs2_en_a, illegal_a;
  logic [31:0] out_pc_a, imm_a;
  logic [6:0] opcode_a, funct7_a;
  logic [4:0] rd_a, rs1_a, rs2_a;
  logic [2:0] funct3_a, fmt_a;
  logic in_ready_b, out_valid_b, rd_en_b, rs1_en_b, rs2_en_b, illegal_b;
  logic [63:0] out_pc_b, imm_b;
  logic [6:0] opcode_b, funct7_b;
  logic [4:0] rd_b, rs1_b, rs2_b;
  logic [2:0] funct3_b, fmt_b;

  decode_stage u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .opcode(opcode_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a),
    .funct3(funct3_a), .funct7(funct7_a), .imm(imm_a), .fmt(fmt_a),
    .rd_en(rd_en_a), .rs1_en(rs1_en_a), .rs2_en(rs2_en_a), .illegal(illegal_a)
  );
  decode_stage #(.XLEN(64), .EN_M(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .opcode(opcode_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b),
    .funct3(funct3_b), .funct7(funct7_b), .imm(imm_b), .fmt(fmt_b),
    .rd_en(rd_en_b), .rs1_en(rs1_en_b), .rs2_en(rs2_en_b), .illegal(illegal_b)
  );

  logic [166:0] obs_a, obs_b;
  assign obs_a = {32'b0, out_pc_a, opcode_a, rd_a, rs1_a, rs2_a, funct3_a, funct7_a,
                  32'b0, imm_a, fmt_a, rd_en_a, rs1_en_a, rs2_en_a, illegal_a};
  assign obs_b = {out_pc_b, opcode_b, rd_b, rs1_b, rs2_b, funct3_b, funct7_b,
                  imm_b, fmt_b, rd_en_b, rs1_en_b, rs2_en_b, illegal_b};

  // Reference decode: format and legality from the opcode table, immediate as a signed integer
  function automatic logic [166:0] exp_vec(logic [63:0] pc, logic [31:0] i, bit x64, bit em);
    logic [6:0] op, f7;
    logic [2:0] f3;
    longint sv;
    logic [63:0] im;
    int f;
    bit ok, r1, r2, rdw;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    ok = 1; f = 7; sv = 0;
    if (op == 7'h37 || op == 7'h17) f = 4;
    else if (op == 7'h6f) f = 5;
    else if (op == 7'h67) begin f = 1; ok = f3 == 0; end
    else if (op == 7'h63) begin f = 3; ok = !(f3 == 2 || f3 == 3); end
    else if (op == 7'h03) begin f = 1; ok = (f3 inside {0, 1, 2, 4, 5}) || (x64 && (f3 inside {3, 6})); end
    else if (op == 7'h23) begin f = 2; ok = f3 <= 2 || (x64 && f3 == 3); end
    else if (op == 7'h13 || op == 7'h0f) f = 1;
    else if (op == 7'h73) begin f = 1; ok = f3 != 4; end
    else if (op == 7'h1b) begin f = 1; ok = x64; end
    else if (op == 7'h33 || op == 7'h3b) begin
      f = 0;
      ok = (op == 7'h33 || x64) && (f7 == 0 || f7 == 7'h20 || (em && f7 == 1));
    end else ok = 0;
    if (!ok) f = 7;
    case (f)
      1: sv = longint'($signed(i[31:20]));
      2: sv = longint'($signed({i[31:25], i[11:7]}));
      3: sv = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      4: sv = longint'($signed({i[31:12], 12'b0}));
      5: sv = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: sv = 0;
    endcase
    im = sv;
    if (!x64) im[63:32] = 32'b0;
    r1 = f inside {0, 1, 2, 3};
    r2 = f inside {0, 2, 3};
    rdw = (f inside {0, 1, 4, 5}) && i[11:7] != 0 && op != 7'h0f;
    return {pc, i[6:0], i[11:7], i[19:15], i[24:20], i[14:12], i[31:25], im, 3'(f), rdw, r1, r2, !ok};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73, 7'h1b, 7'h3b};
    logic [31:0] w;
    int k;
    w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 12)];
    k = $urandom_range(0, 5);
    if (k < 3) w[31:25] = k == 0 ? 7'h00 : k == 1 ? 7'h20 : 7'h01;
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 1; in_instr = 32'h0611F193; in_pc = 64'h40;
    tick; tick;
    vectors++;
    if ({in_ready_a, in_ready_b, out_valid_a, out_valid_b} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_hs: got %b exp 0000", {in_ready_a, in_ready_b, out_valid_a, out_valid_b});
    end
    vectors++;
    if (obs_a !== '0 || obs_b !== '0) begin
      miscompares++; $display("FAIL reset_data: got a=%h b=%h exp 0", obs_a, obs_b);
    end
    rst_n = 1; in_valid = 0;
    tick;
    vectors++;
    if ({in_ready_a, in_ready_b, out_valid_a, out_valid_b} !== 4'b1100) begin
      miscompares++; $display("FAIL reset_release: got %b exp 1100", {in_ready_a, in_ready_b, out_valid_a, out_valid_b});
    end
  endtask

  task automatic test_and;
    out_ready = 1; in_valid = 1; in_instr = 32'h0011F1B3; in_pc = 64'h100;
    tick;
    in_valid = 0;
    vectors++;
    if ({out_valid_a, fmt_a, rd_a, rs1_a, rs2_a, funct3_a, imm_a, rd_en_a, rs1_en_a, rs2_en_a, illegal_a} !==
        {1'b1, 3'd0, 5'd3, 5'd3, 5'd1, 3'd7, 32'd0, 4'b1110}) begin
      miscompares++; $display("FAIL and: got fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h en=%b%b%b ill=%b",
        fmt_a, rd_a, rs1_a, rs2_a, funct3_a, imm_a, rd_en_a, rs1_en_a, rs2_en_a, illegal_a);
    end
    vectors++;
    if (obs_a !== exp_vec(64'h100, 32'h0011F1B3, 0, 0)) begin
      miscompares++; $display("FAIL and_model: got %h exp %h", obs_a, exp_vec(64'h100, 32'h0011F1B3, 0, 0));
    end
    tick;
    vectors++;
    if (out_valid_a !== 1'b0) begin
      miscompares++; $display("FAIL and_drain: out_valid got %b exp 0", out_valid_a);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1; in_valid = 1; in_instr = 32'h0611F193; in_pc = 64'h200;
    tick;
    vectors++;
    if ({out_valid_a, fmt_a, imm_a, rs2_en_a, out_pc_a} !== {1'b1, 3'd1, 32'h61, 1'b0, 32'h200}) begin
      miscompares++; $display("FAIL b2b_andi: got v=%b fmt=%0d imm=%h rs2_en=%b pc=%h", out_valid_a, fmt_a, imm_a, rs2_en_a, out_pc_a);
    end
    in_instr = 32'h0011F1E3; in_pc = 64'h204;
    vectors++;
    if (in_ready_a !== 1'b1) begin
      miscompares++; $display("FAIL b2b_ready: got %b exp 1", in_ready_a);
    end
    tick;
    in_valid = 0;
    vectors++;
    if ({out_valid_a, fmt_a, imm_a, rd_en_a, out_pc_a} !== {1'b1, 3'd3, 32'h802, 1'b0, 32'h204}) begin
      miscompares++; $display("FAIL b2b_bgeu: got v=%b fmt=%0d imm=%h rd_en=%b pc=%h", out_valid_a, fmt_a, imm_a, rd_en_a, out_pc_a);
    end
    tick;
    vectors++;
    if (out_valid_a !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain: out_valid got %b exp 0", out_valid_a);
    end
  endtask

  task automatic test_sign_ext;
    logic [31:0] ins [2] = '{32'hFFF00093, 32'h800000B7};
    logic [31:0] ea [2] = '{32'hFFFFFFFF, 32'h80000000};
    logic [63:0] eb [2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000};
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_instr = ins[k]; in_pc = 64'h300 + 64'(4 * k);
      tick;
      in_valid = 0;
      vectors++;
      if (imm_a !== ea[k] || imm_b !== eb[k]) begin
        miscompares++; $display("FAIL sext_%0d: got a=%h b=%h exp a=%h b=%h", k, imm_a, imm_b, ea[k], eb[k]);
      end
    end
    tick;
  endtask

  task automatic test_illegal;
    out_ready = 1; in_valid = 1; in_instr = 32'h0011F1F7; in_pc = 64'h400;
    tick;
    vectors++;
    if ({illegal_a, fmt_a, imm_a, rd_en_a, rs1_en_a, rs2_en_a, rd_a} !== {1'b1, 3'd7, 32'd0, 3'b000, 5'd3}) begin
      miscompares++; $display("FAIL ill_opcode: got ill=%b fmt=%0d imm=%h en=%b%b%b rd=%0d", illegal_a, fmt_a, imm_a, rd_en_a, rs1_en_a, rs2_en_a, rd_a);
    end
    in_instr = 32'h0011F1B0;
    tick;
    vectors++;
    if ({illegal_a, illegal_b, fmt_a} !== {2'b11, 3'd7}) begin
      miscompares++; $display("FAIL ill_lowbits: got ill=%b%b fmt=%0d exp 11 7", illegal_a, illegal_b, fmt_a);
    end
    in_instr = 32'h022081B3;
    tick;
    in_valid = 0;
    vectors++;
    if ({illegal_a, illegal_b, fmt_b, rd_en_b} !== {2'b10, 3'd0, 1'b1}) begin
      miscompares++; $display("FAIL ill_mext: got ill=%b%b fmt_b=%0d rd_en_b=%b exp 10 0 1", illegal_a, illegal_b, fmt_b, rd_en_b);
    end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 0; in_valid = 1; in_instr = 32'h0611F193; in_pc = 64'hA0;
    tick;
    vectors++;
    if ({out_valid_a, out_pc_a, in_ready_a} !== {1'b1, 32'hA0, 1'b1}) begin
      miscompares++; $display("FAIL bp_first: got v=%b pc=%h rdy=%b", out_valid_a, out_pc_a, in_ready_a);
    end
    in_instr = 32'h0011F1B3; in_pc = 64'hB0;
    tick;
    vectors++;
    if ({out_pc_a, in_ready_a, in_ready_b} !== {32'hA0, 2'b00}) begin
      miscompares++; $display("FAIL bp_skid: got pc=%h rdy=%b%b exp a0 00", out_pc_a, in_ready_a, in_ready_b);
    end
    in_instr = 32'h0011F1E3; in_pc = 64'hC0;
    tick; tick;
    vectors++;
    if ({out_valid_a, out_pc_a, opcode_a, imm_a, in_ready_a} !== {1'b1, 32'hA0, 7'h13, 32'h61, 1'b0}) begin
      miscompares++; $display("FAIL bp_hold: got v=%b pc=%h op=%h imm=%h rdy=%b", out_valid_a, out_pc_a, opcode_a, imm_a, in_ready_a);
    end
    out_ready = 1;
    tick;
    vectors++;
    if ({out_valid_a, out_pc_a, opcode_a, in_ready_a} !== {1'b1, 32'hB0, 7'h33, 1'b1}) begin
      miscompares++; $display("FAIL bp_second: got v=%b pc=%h op=%h rdy=%b", out_valid_a, out_pc_a, opcode_a, in_ready_a);
    end
    tick;
    in_valid = 0;
    vectors++;
    if ({out_valid_a, out_pc_a, opcode_a} !== {1'b1, 32'hC0, 7'h63}) begin
      miscompares++; $display("FAIL bp_third: got v=%b pc=%h op=%h", out_valid_a, out_pc_a, opcode_a);
    end
    tick;
    vectors++;
    if (out_valid_a !== 1'b0) begin
      miscompares++; $display("FAIL bp_drain: out_valid got %b exp 0", out_valid_a);
    end
  endtask

  task automatic test_flush;
    out_ready = 0; in_valid = 1; in_instr = 32'h0611F193; in_pc = 64'hA0;
    tick;
    in_pc = 64'hB0;
    tick;
    in_pc = 64'hD0; flush = 1;
    tick;
    flush = 0; in_valid = 0;
    vectors++;
    if ({out_valid_a, out_valid_b, in_ready_a, in_ready_b} !== 4'b0011) begin
      miscompares++; $display("FAIL flush_full: got %b exp 0011", {out_valid_a, out_valid_b, in_ready_a, in_ready_b});
    end
    out_ready = 1;
    tick; tick;
    vectors++;
    if (out_valid_a !== 1'b0) begin
      miscompares++; $display("FAIL flush_no_replay: out_valid got %b exp 0 pc=%h", out_valid_a, out_pc_a);
    end
    in_valid = 1; in_pc = 64'hE0; flush = 1;
    tick;
    flush = 0; in_valid = 0;
    tick;
    vectors++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      miscompares++; $display("FAIL flush_drop: got v=%b rdy=%b exp 0 1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_random;
    logic [95:0] q [$];
    logic [63:0] pc;
    logic [31:0] ins;
    for (int c = 0; c < 405; c++) begin
      in_valid = c < 400 && $urandom_range(0, 3) != 0;
      out_ready = c >= 400 || $urandom_range(0, 2) != 0;
      in_instr = rand_instr();
      in_pc = {$urandom, $urandom};
      vectors++;
      if ({in_ready_a, in_ready_b, out_valid_a, out_valid_b} !== {{2{q.size() < 2}}, {2{q.size() > 0}}}) begin
        miscompares++; $display("FAIL rand_hs c=%0d: got %b occupancy %0d", c, {in_ready_a, in_ready_b, out_valid_a, out_valid_b}, q.size());
      end
      if (out_valid_a && out_ready && q.size() > 0) begin
        pc = q[0][95:32];
        ins = q[0][31:0];
        vectors += 2;
        if (obs_a !== exp_vec({32'b0, pc[31:0]}, ins, 0, 0)) begin
          miscompares++; $display("FAIL rand_a c=%0d instr=%h: got %h exp %h", c, ins, obs_a, exp_vec({32'b0, pc[31:0]}, ins, 0, 0));
        end
        if (obs_b !== exp_vec(pc, ins, 1, 1)) begin
          miscompares++; $display("FAIL rand_b c=%0d instr=%h: got %h exp %h", c, ins, obs_b, exp_vec(pc, ins, 1, 1));
        end
        void'(q.pop_front());
      end
      if (in_valid && in_ready_a) q.push_back({in_pc, in_instr});
      tick;
    end
    in_valid = 0;
    vectors++;
    if (q.size() != 0 || out_valid_a !== 1'b0) begin
      miscompares++; $display("FAIL rand_drain: got %0d left v=%b exp 0 0", q.size(), out_valid_a);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 0; in_valid = 1; in_instr = 32'hFFF00093; in_pc = 64'h500;
    tick; tick;
    rst_n = 0;
    tick;
    vectors++;
    if ({out_valid_a, out_valid_b, in_ready_a, in_ready_b} !== 4'b0000 || obs_a !== '0 || obs_b !== '0) begin
      miscompares++; $display("FAIL reset_mid: got hs=%b a=%h b=%h exp all 0", {out_valid_a, out_valid_b, in_ready_a, in_ready_b}, obs_a, obs_b);
    end
    tick;
    vectors++;
    if ({in_ready_a, in_ready_b} !== 2'b00) begin
      miscompares++; $display("FAIL reset_mid_ready: got %b exp 00", {in_ready_a, in_ready_b});
    end
    rst_n = 1; in_valid = 0; out_ready = 1;
    tick;
    vectors++;
    if ({in_ready_a, out_valid_a} !== 2'b10) begin
      miscompares++; $display("FAIL reset_mid_release: got rdy=%b v=%b exp 1 0", in_ready_a, out_valid_a);
    end
  endtask

  initial begin
    test_reset;
    test_and;
    test_back_to_back;
    test_sign_ext;
    test_illegal;
    test_backpressure;
    test_flush;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32/RV64 instruction decode pipeline stage. It accepts a 32-bit instruction word and its PC over a valid/ready handshake and splits the word into register fields. It also generates a sign-extended XLEN-wide immediate for every base format, classifies the format, derives register-use enables and flags illegal encodings. It sits between the fetch stage and the register-read/control stage, and an optional skid buffer keeps `in_ready` fully registered.

## Interface
- `XLEN`, 32, datapath width; only 32 or 64 legal. 64 enables the RV64 opcodes and funct3 values.
- `EN_M`, 0, when 1, OP/OP-32 with funct7=0000001 is legal.
- `SKID`, 1, when 1, a 1-entry skid buffer is present and `in_ready` is a flop; when 0, `in_ready = !out_valid || out_ready`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `flush`  in  1  discards all held instructions.
- `in_valid`  in  1  `in_instr`/`in_pc` are valid.
- `in_ready`  out  1  the stage accepts this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of the instruction.
- `out_valid`  out  1  decoded outputs are valid.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_pc`  out  XLEN  PC of the instruction, passed through.
- `opcode`  out  7  `instr[6:0]`.
- `rd`, `rs1`, `rs2`  out  5 each  `instr[11:7]`, `[19:15]`, `[24:20]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7`  out  7  `instr[31:25]`.
- `imm`  out  XLEN  sign-extended immediate.
- `fmt`  out  3  instruction format: R=0, I=1, S=2, B=3, U=4, J=5, none=7.
- `rd_en`, `rs1_en`, `rs2_en`  out  1 each  register write/read enables.
- `illegal`  out  1  illegal encoding.

## Operation
- **Immediate generation:**
  - I: sext(`instr[31:20]`).
  - S: sext({`[31:25]`,`[11:7]`}).
  - B: sext({`[31]`,`[7]`,`[30:25]`,`[11:8]`,0}).
  - U: sext({`[31:12]`,12'b0}).
  - J: sext({`[31]`,`[19:12]`,`[20]`,`[30:21]`,0}).
  - R and illegal: 0.
  - All sign extension is from bit 31 of the word to XLEN.
- **Opcode map:**
  - LUI 0110111 → U; AUIPC 0010111 → U; JAL 1101111 → J.
  - JALR 1100111 → I; only funct3=000 is legal.
  - BRANCH 1100011 → B; funct3 010/011 are illegal.
  - LOAD 0000011 → I; funct3 000, 001, 010, 100, 101 legal; 011 and 110 also legal when XLEN=64.
  - STORE 0100011 → S; funct3 000, 001, 010 legal; 011 also legal when XLEN=64.
  - OP-IMM 0010011 → I.
  - OP 0110011 → R; funct7 0000000/0100000 legal, plus 0000001 when EN_M.
  - MISC-MEM 0001111 → I.
  - SYSTEM 1110011 → I; funct3=100 is illegal.
  - OP-IMM-32 0011011 → I, legal only when XLEN=64.
  - OP-32 0111011 → R, legal only when XLEN=64.
- **Illegal instructions:**
  - Any of the following is illegal: `instr[1:0]` != 11, an unlisted opcode, or a disallowed funct field.
  - An illegal instruction gives `illegal`=1, `fmt`=7, `imm`=0 and all enables 0.
  - It still flows through the handshake normally.
- **Register enables:**
  - `rs1_en`=1 for R/I/S/B formats.
  - `rs2_en`=1 for R/S/B formats.
  - `rd_en`=1 for R/I/U/J formats with `rd` != 0, excluding MISC-MEM.
- **Raw fields:** `rd`, `rs1`, `rs2`, `funct3`, `funct7` and `opcode` are always the raw instruction bits, even when the instruction is illegal.
- **Skid buffer (SKID=1):**
  - States are EMPTY (`in_ready`=1) and FULL (`in_ready`=0).
  - EMPTY → FULL: an accept happens while `out_valid` && !`out_ready`; the accepted instruction and its decode go into the skid entry.
  - FULL → EMPTY: on `out_ready`, the skid entry moves into the output register.
  - An accept while the output register is empty or being consumed loads the output register directly.
- **Flush:**
  - Clears `out_valid` and the skid entry, and forces EMPTY.
  - Any instruction presented in the same cycle as `flush` is dropped, even if `in_valid` && `in_ready`.

## Timing
- **Latency:** 1 cycle from an accepted input to `out_valid`, with decode computed before the output register. Throughput is 1 instruction per cycle while `out_ready`=1.
- **Reset** (`rst_n`=0 at a rising edge):
  - `out_valid`=0, skid state EMPTY.
  - All data outputs are 0, including `fmt`=0 and `illegal`=0.
  - `in_ready`=0 while `rst_n` is low and 1 in the first cycle after release.
  - A reset in mid-stream drops all held instructions.
- **Output stability:** while `out_valid` && !`out_ready`, every output holds stable.
- **Transfers:**
  - An input transfer occurs on `in_valid` && `in_ready`.
  - An output transfer occurs on `out_valid` && `out_ready`.
  - A simultaneous input and output transfer leaves occupancy unchanged.
- **Ready path:** with SKID=1 there is no combinational path from `out_ready` to `in_ready`.
- **Priority:** `rst_n` > `flush` > handshake.

## Test plan
- **AND:** `in_instr`=0x0011F1B3 (AND x3,x3,x1) → next cycle `fmt`=0, `rd`=3, `rs1`=3, `rs2`=1, `funct3`=7, `imm`=0, `rd_en`=1, `rs2_en`=1, `illegal`=0.
- **ANDI and branch, back-to-back with `out_ready`=1:**
  - 0x0611F193 (ANDI x3,x3,0x61) → `fmt`=1, `imm`=0x61, `rs2_en`=0.
  - 0x0011F1E3 (BGEU) → `fmt`=3, `imm`=0x802, `rd_en`=0.
  - One output per cycle, no bubbles.
- **Sign extension:**
  - 0xFFF00093 (ADDI x1,x0,-1) → `imm`=0xFFFFFFFF; with XLEN=64, 0xFFFFFFFFFFFFFFFF.
  - 0x800000B7 (LUI) → `imm`=0x80000000; with XLEN=64, 0xFFFFFFFF80000000.
- **Illegal encodings:**
  - 0x0011F1F7 (unknown opcode) → `illegal`=1, `fmt`=7, all enables 0.
  - 0x0011F1B0 (low bits 00) → `illegal`=1.
  - OP with funct7=0000001 → `illegal`=1 when EN_M=0, 0 when EN_M=1.
- **Backpressure:**
  - Hold `out_ready`=0 and stream 3 instructions → first is output, second is in skid, `in_ready`=0 the cycle after the second is accepted, third is held upstream.
  - Release `out_ready` → outputs appear in order, with no loss or duplication.
- **Flush and reset:**
  - `flush` with both entries full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flush-cycle input is never output.
  - `rst_n`=0 in mid-stream → all outputs 0 and `in_ready`=0 while low.
